// File: rtl/uart_cmd_dispatcher_if.sv
// ----------------------------------------------------------------------------
// uart_cmd_dispatcher_if
// Bundles the three handshakes of the UART command dispatcher:
//   rx side   : rx_data, rx_done (level, a rising edge marks one received pair)
//   dev side  : dev_req/dev_cmd/dev_addr out, dev_ack/dev_data/dev_err back
//   resp side : resp_valid/resp_code/resp_data out, resp_ready back
// Handshake semantics: dev_req stays high with dev_cmd/dev_addr stable until
// the cycle dev_ack is sampled high; resp_valid stays high with
// resp_code/resp_data stable until the cycle resp_valid & resp_ready is
// sampled high, after which resp_valid drops on the next clock.
// Modports: slave = dispatcher, master = environment (receiver/sensor/tx).
// ----------------------------------------------------------------------------
interface uart_cmd_dispatcher_if #(
  parameter int ADDR_W = 5
);
  logic [15:0]       rx_data;
  logic              rx_done;
  logic              dev_req;
  logic [7:0]        dev_cmd;
  logic [ADDR_W-1:0] dev_addr;
  logic              dev_ack;
  logic [15:0]       dev_data;
  logic              dev_err;
  logic              resp_valid;
  logic [7:0]        resp_code;
  logic [15:0]       resp_data;
  logic              resp_ready;

  modport slave (
    input  rx_data, rx_done, dev_ack, dev_data, dev_err, resp_ready,
    output dev_req, dev_cmd, dev_addr, resp_valid, resp_code, resp_data
  );

  modport master (
    output rx_data, rx_done, dev_ack, dev_data, dev_err, resp_ready,
    input  dev_req, dev_cmd, dev_addr, resp_valid, resp_code, resp_data
  );
endinterface

// File: rtl/uart_cmd_dispatcher.sv
// ----------------------------------------------------------------------------
// uart_cmd_dispatcher
// Takes each 2-byte request from the UART receiver ({address, command}),
// validates it, forwards valid ones to the addressed sensor and returns a
// single response word to the UART transmit side.
// Ports:
//   clk_9k6hz   clock shared with the receiver
//   rst_n       asynchronous active-low reset
//   bus         uart_cmd_dispatcher_if.slave (rx, sensor and response sides)
//   busy        high whenever the FSM is not IDLE
//   drop_cnt    requests that arrived while busy, saturating at 8'hFF
//   o_dbg_state current FSM state (debug)
// ----------------------------------------------------------------------------
module uart_cmd_dispatcher #(
  parameter int          NUM_DEV     = 32,
  parameter int          ADDR_W      = 5,
  parameter logic [7:0]  MAX_CMD     = 8'h07,
  parameter int          TIMEOUT_CYC = 4800
) (
  input  logic                       clk_9k6hz,
  input  logic                       rst_n,
  uart_cmd_dispatcher_if.slave       bus,
  output logic                       busy,
  output logic [7:0]                 drop_cnt,
  output logic [1:0]                 o_dbg_state
);

  localparam int              CNT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  // 9 bits so that NUM_DEV = 256 still compares correctly against 8-bit addr
  localparam logic [8:0]      NUM_DEV_9 = 9'(NUM_DEV);

  localparam logic [7:0] CODE_OK      = 8'h00;
  localparam logic [7:0] CODE_BAD_CMD = 8'hE1;
  localparam logic [7:0] CODE_BAD_ADR = 8'hE2;
  localparam logic [7:0] CODE_TIMEOUT = 8'hE3;
  localparam logic [7:0] CODE_DEV_ERR = 8'hE4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_REQ   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic              r_rx_done_q;
  logic [7:0]        r_cmd;
  logic [7:0]        r_addr;
  logic [CNT_W-1:0]  r_tmo_cnt;
  logic              r_dev_req;
  logic [7:0]        r_dev_cmd;
  logic [ADDR_W-1:0] r_dev_addr;
  logic              r_resp_valid;
  logic [7:0]        r_resp_code;
  logic [15:0]       r_resp_data;
  logic [7:0]        r_drop_cnt;

  logic              w_new_req;
  logic              w_issue;    // CHECK passed: raise dev_req
  logic              w_finish;   // response word is decided this cycle
  logic              w_release;  // response taken by consumer
  logic [7:0]        w_code;
  logic [15:0]       w_payload;

  // One request per rising edge of the receiver's "concluded" level.
  assign w_new_req = bus.rx_done & ~r_rx_done_q;

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_finish     = 1'b0;
    w_release    = 1'b0;
    w_code       = CODE_OK;
    w_payload    = {r_addr, r_cmd};
    case (r_state)
      ST_IDLE: begin
        if (w_new_req) w_state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (r_cmd > MAX_CMD) begin
          w_finish     = 1'b1;
          w_code       = CODE_BAD_CMD;
          w_state_next = ST_RESP;
        end else if ({1'b0, r_addr} >= NUM_DEV_9) begin
          w_finish     = 1'b1;
          w_code       = CODE_BAD_ADR;
          w_state_next = ST_RESP;
        end else begin
          w_issue      = 1'b1;
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        // Ack is tested first so an ack on the expiry cycle still wins.
        if (bus.dev_ack) begin
          w_finish     = 1'b1;
          w_state_next = ST_RESP;
          if (bus.dev_err) begin
            w_code = CODE_DEV_ERR;
          end else begin
            w_code    = CODE_OK;
            w_payload = bus.dev_data;
          end
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_finish     = 1'b1;
          w_code       = CODE_TIMEOUT;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          w_release    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_9k6hz or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk_9k6hz or negedge rst_n) begin
    if (!rst_n) begin
      // Treat a level already high at reset release as old news.
      r_rx_done_q  <= 1'b1;
      r_cmd        <= '0;
      r_addr       <= '0;
      r_tmo_cnt    <= '0;
      r_dev_req    <= 1'b0;
      r_dev_cmd    <= '0;
      r_dev_addr   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_code  <= '0;
      r_resp_data  <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_rx_done_q <= bus.rx_done;

      if (r_state == ST_IDLE && w_new_req) begin
        r_cmd  <= bus.rx_data[7:0];
        r_addr <= bus.rx_data[15:8];
      end

      // Edge arriving while busy is consumed here and never replayed.
      if (r_state != ST_IDLE && w_new_req && r_drop_cnt != 8'hFF)
        r_drop_cnt <= r_drop_cnt + 8'd1;

      if (r_state == ST_REQ && !w_finish) r_tmo_cnt <= r_tmo_cnt + 1'b1;
      else                                r_tmo_cnt <= '0;

      if (w_issue) begin
        r_dev_req  <= 1'b1;
        r_dev_cmd  <= r_cmd;
        r_dev_addr <= r_addr[ADDR_W-1:0];
      end else if (r_state == ST_REQ && w_finish) begin
        r_dev_req  <= 1'b0;
      end

      if (w_finish) begin
        r_resp_valid <= 1'b1;
        r_resp_code  <= w_code;
        r_resp_data  <= w_payload;
      end else if (w_release) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign bus.dev_req    = r_dev_req;
  assign bus.dev_cmd    = r_dev_cmd;
  assign bus.dev_addr   = r_dev_addr;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_code  = r_resp_code;
  assign bus.resp_data  = r_resp_data;
  assign busy           = (r_state != ST_IDLE);
  assign drop_cnt       = r_drop_cnt;
  assign o_dbg_state    = r_state;

endmodule
